// File: rtl/glyph_ram_writer.sv
// Unpacks a header+pixel byte stream into single-bit writes of the letter glyph memory
// at letter*GLYPH_PIX + pixel, and tracks which letters hold a complete glyph.
module glyph_ram_writer #(
  parameter int GLYPH_PIX   = 2500,
  parameter int NUM_LETTERS = 26,
  parameter int ADDR_W      = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   abort,
  output logic [ADDR_W-1:0]      wr_addr,
  output logic                   wr_data,
  output logic                   wr_en,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [NUM_LETTERS-1:0] loaded
);
  localparam int NUM_BYTES = (GLYPH_PIX + 7) / 8;
  localparam int PIX_W     = $clog2(GLYPH_PIX);
  localparam int BYTE_W    = $clog2(NUM_BYTES);
  localparam int CODE_W    = $clog2(NUM_LETTERS);

  localparam logic [PIX_W-1:0]  LAST_PIX  = PIX_W'(GLYPH_PIX - 1);
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NUM_BYTES - 1);
  localparam logic [ADDR_W-1:0] PIX_K     = ADDR_W'(GLYPH_PIX);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_BYTE = 2'd1;
  localparam logic [1:0] SHIFT     = 2'd2;
  localparam logic [1:0] SKIP      = 2'd3;

  logic [1:0]             state_q, state_d;
  logic [7:0]             shift_q, shift_d;
  logic [ADDR_W-1:0]      base_q, base_d;
  logic [PIX_W-1:0]       pix_q, pix_d;
  logic [2:0]             bit_q, bit_d;
  logic [BYTE_W-1:0]      skip_q, skip_d;
  logic [CODE_W-1:0]      code_q, code_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic [NUM_LETTERS-1:0] loaded_q, loaded_d;

  logic                   accept;
  logic                   code_ok;
  logic [ADDR_W-1:0]      hdr_base;
  logic [NUM_LETTERS-1:0] letter_mask;

  assign in_ready = resetn && (state_q != SHIFT);
  assign accept   = in_valid && in_ready;
  assign code_ok  = (in_data < 8'(NUM_LETTERS));

  // code*GLYPH_PIX as a sum of shifted copies of the code, one per set bit of GLYPH_PIX
  always_comb begin
    hdr_base = '0;
    for (int i = 0; i < ADDR_W; i++) begin
      if (PIX_K[i]) hdr_base = hdr_base + (ADDR_W'(in_data[CODE_W-1:0]) << i);
    end
  end

  always_comb begin
    letter_mask = '0;
    for (int n = 0; n < NUM_LETTERS; n++) begin
      letter_mask[n] = (code_q == CODE_W'(n));
    end
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    base_d   = base_q;
    pix_d    = pix_q;
    bit_d    = bit_q;
    skip_d   = skip_q;
    code_d   = code_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    loaded_d = loaded_q;
    case (state_q)
      IDLE: begin
        // abort coinciding with the header consumes and drops it
        if (accept && !abort) begin
          code_d = in_data[CODE_W-1:0];
          base_d = hdr_base;
          pix_d  = '0;
          bit_d  = '0;
          skip_d = '0;
          if (code_ok) begin
            state_d = WAIT_BYTE;
          end else begin
            state_d = SKIP;
            err_d   = 1'b1;
          end
        end
      end
      WAIT_BYTE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (accept) begin
          shift_d = in_data;
          bit_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          shift_d = {1'b0, shift_q[7:1]};
          pix_d   = pix_q + PIX_W'(1);
          bit_d   = bit_q + 3'd1;
          if (pix_q == LAST_PIX) begin
            state_d  = IDLE;
            done_d   = 1'b1;
            loaded_d = loaded_q | letter_mask;
          end else if (bit_q == 3'd7) begin
            state_d = WAIT_BYTE;
          end
        end
      end
      SKIP: begin
        if (abort) begin
          state_d = IDLE;
        end else if (accept) begin
          if (skip_q == LAST_BYTE) state_d = IDLE;
          else                     skip_d  = skip_q + BYTE_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      base_q   <= '0;
      pix_q    <= '0;
      bit_q    <= '0;
      skip_q   <= '0;
      code_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      loaded_q <= '0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      base_q   <= base_d;
      pix_q    <= pix_d;
      bit_q    <= bit_d;
      skip_q   <= skip_d;
      code_q   <= code_d;
      done_q   <= done_d;
      err_q    <= err_d;
      loaded_q <= loaded_d;
    end
  end

  assign wr_en   = (state_q == SHIFT);
  assign wr_data = wr_en & shift_q[0];
  assign wr_addr = wr_en ? (base_q + ADDR_W'(pix_q)) : '0;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign err     = err_q;
  assign loaded  = loaded_q;

endmodule

// File: tb/tb_glyph_ram_writer.sv
// Directed bench for glyph_ram_writer: table of whole frames plus abort, header-drop and
// mid-frame reset sequences; a negedge monitor scores every write against the frame model.
module tb_glyph_ram_writer;
  localparam int GP = 2500;
  localparam int NB = 313;

  logic        clk = 1'b0;
  logic        resetn;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        abort;
  logic [15:0] wr_addr;
  logic        wr_data;
  logic        wr_en;
  logic        busy;
  logic        done;
  logic        err;
  logic [25:0] loaded;

  always #5 clk = ~clk;

  glyph_ram_writer #(.GLYPH_PIX(2500), .NUM_LETTERS(26), .ADDR_W(16)) dut (
    .clk(clk), .resetn(resetn), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .abort(abort), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_en(wr_en), .busy(busy), .done(done), .err(err), .loaded(loaded)
  );

  typedef struct {
    logic [7:0]  code;
    logic [7:0]  pat;
    bit          gappy;
    int          exp_writes;
    int          exp_first;
    int          exp_last;
    int          exp_done;
    int          exp_err;
    logic [25:0] exp_loaded;
  } vec_t;

  int checks = 0;
  int errors = 0;
  bit tmo = 1'b0;

  // monitor-owned tallies
  int wr_total = 0, bad_total = 0, rlow_total = 0;
  int done_total = 0, err_total = 0, both_total = 0;
  int first_addr = 0, last_addr = 0, mon_idx = 0;
  // frame model, written by the stimulus only while the DUT is idle
  int frame_start = 0, cur_base = 0;
  logic [7:0] cur_pat = 8'h00;

  always @(negedge clk) begin
    if (resetn) begin
      if (wr_en) begin
        mon_idx = wr_total - frame_start;
        if (mon_idx == 0) first_addr = int'(wr_addr);
        last_addr = int'(wr_addr);
        if (wr_addr !== 16'(cur_base + mon_idx) || wr_data !== cur_pat[mon_idx % 8])
          bad_total++;
        wr_total++;
        if (in_ready) both_total++;
      end
      if (busy && !in_ready) rlow_total++;
      if (done) done_total++;
      if (err) err_total++;
      if (done && err) both_total++;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gappy);
    int n;
    if (tmo) return;
    if (gappy && $urandom_range(1) == 1) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tmo = 1'b1;
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got in_ready=0 for 64 cycles expected 1");
      return;
    end
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 64'(busy), 64'(0));
  endtask

  task automatic run_check(input vec_t v);
    int s_wr, s_bad, s_rl, s_dn, s_er, s_bo;
    s_wr = wr_total; s_bad = bad_total; s_rl = rlow_total;
    s_dn = done_total; s_er = err_total; s_bo = both_total;
    cur_base    = int'(v.code) * GP;
    cur_pat     = v.pat;
    frame_start = wr_total;
    send_byte(v.code, v.gappy);
    for (int i = 0; i < NB; i++) send_byte(v.pat, v.gappy);
    in_valid = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    chk("write_count", 64'(wr_total - s_wr), 64'(v.exp_writes));
    chk("write_seq_bad", 64'(bad_total - s_bad), 64'(0));
    chk("ready_low_cycles", 64'(rlow_total - s_rl), 64'(v.exp_writes));
    chk("done_pulses", 64'(done_total - s_dn), 64'(v.exp_done));
    chk("err_pulses", 64'(err_total - s_er), 64'(v.exp_err));
    chk("overlap", 64'(both_total - s_bo), 64'(0));
    chk("loaded", 64'(loaded), 64'(v.exp_loaded));
    chk("busy_after", 64'(busy), 64'(0));
    if (v.exp_writes > 0) begin
      chk("first_addr", 64'(first_addr), 64'(v.exp_first));
      chk("last_addr", 64'(last_addr), 64'(v.exp_last));
    end
    $display("frame code=%0d pat=%02h gappy=%0d writes=%0d done=%0d err=%0d loaded=%07h",
             v.code, v.pat, v.gappy, wr_total - s_wr, done_total - s_dn,
             err_total - s_er, loaded);
  endtask

  vec_t tbl[5];
  vec_t v;
  int   s_wr, s_dn;

  initial begin
    tbl[0] = '{code: 8'd0,  pat: 8'hFF, gappy: 1'b0, exp_writes: 2500, exp_first: 0,
               exp_last: 2499,  exp_done: 1, exp_err: 0, exp_loaded: 26'h0000001};
    tbl[1] = '{code: 8'd25, pat: 8'hA5, gappy: 1'b0, exp_writes: 2500, exp_first: 62500,
               exp_last: 64999, exp_done: 1, exp_err: 0, exp_loaded: 26'h2000001};
    tbl[2] = '{code: 8'd26, pat: 8'h5A, gappy: 1'b0, exp_writes: 0,    exp_first: 0,
               exp_last: 0,     exp_done: 0, exp_err: 1, exp_loaded: 26'h2000001};
    tbl[3] = '{code: 8'd7,  pat: 8'h3C, gappy: 1'b1, exp_writes: 2500, exp_first: 17500,
               exp_last: 19999, exp_done: 1, exp_err: 0, exp_loaded: 26'h2000081};
    tbl[4] = '{code: 8'd7,  pat: 8'h3C, gappy: 1'b0, exp_writes: 2500, exp_first: 17500,
               exp_last: 19999, exp_done: 1, exp_err: 0, exp_loaded: 26'h2000081};

    resetn = 1'b0; in_valid = 1'b0; in_data = 8'h00; abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_wr_en", 64'(wr_en), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_loaded", 64'(loaded), 64'(0));
    resetn = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 64'(in_ready), 64'(1));
    chk("idle_wr_addr", 64'(wr_addr), 64'(0));
    $display("reset released in_ready=%0d busy=%0d", in_ready, busy);

    for (int i = 0; i < 5; i++) run_check(tbl[i]);

    // letter 3 abandoned after 100 data bytes
    s_wr = wr_total; s_dn = done_total;
    cur_base = 3 * GP; cur_pat = 8'hFF; frame_start = wr_total;
    send_byte(8'd3, 1'b0);
    send_byte(8'hFF, 1'b0);
    chk("first_write_latency", 64'(wr_en), 64'(1));
    chk("first_write_addr", 64'(wr_addr), 64'(7500));
    for (int i = 1; i < 100; i++) send_byte(8'hFF, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_wr_en", 64'(wr_en), 64'(0));
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_in_ready", 64'(in_ready), 64'(1));
    chk("abort_writes", 64'(wr_total - s_wr), 64'(99 * 8 + 2));
    repeat (10) @(negedge clk);
    chk("abort_no_done", 64'(done_total - s_dn), 64'(0));
    chk("abort_loaded", 64'(loaded), 64'(26'h2000081));
    $display("abort letter=3 writes=%0d loaded=%07h", wr_total - s_wr, loaded);
    v = '{code: 8'd3, pat: 8'h0F, gappy: 1'b0, exp_writes: 2500, exp_first: 7500,
          exp_last: 9999, exp_done: 1, exp_err: 0, exp_loaded: 26'h2000089};
    run_check(v);

    // abort on the header cycle drops the header, even a bad one
    in_data = 8'd30; in_valid = 1'b1; abort = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; abort = 1'b0;
    chk("hdr_drop_busy", 64'(busy), 64'(0));
    @(negedge clk);
    chk("hdr_drop_err", 64'(err), 64'(0));
    $display("header drop busy=%0d err=%0d", busy, err);

    // reset in the middle of letter 2
    cur_base = 2 * GP; cur_pat = 8'h81; frame_start = wr_total;
    send_byte(8'd2, 1'b0);
    for (int i = 0; i < 5; i++) send_byte(8'h81, 1'b0);
    in_valid = 1'b0;
    chk("pre_rst_shifting", 64'(wr_en), 64'(1));
    chk("pre_rst_loaded0", 64'(loaded[0]), 64'(1));
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst_wr_en", 64'(wr_en), 64'(0));
    chk("mid_rst_wr_addr", 64'(wr_addr), 64'(0));
    chk("mid_rst_wr_data", 64'(wr_data), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_loaded", 64'(loaded), 64'(0));
    chk("mid_rst_in_ready", 64'(in_ready), 64'(0));
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'(1));
    $display("mid-frame reset loaded=%07h in_ready=%0d", loaded, in_ready);
    v = '{code: 8'd0, pat: 8'h96, gappy: 1'b0, exp_writes: 2500, exp_first: 0,
          exp_last: 2499, exp_done: 1, exp_err: 0, exp_loaded: 26'h0000001};
    run_check(v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
